alu_seq: RTL

- Registered, parametrised successor of the nanoprocesseur combinational ALU.
- Accepts an operation with a start/done handshake and latches operands on acceptance.
- Single-cycle ops complete in 1 clock; the optional multiply iterates over WIDTH clocks.
- Sits between the accumulator/RAM datapath and the control FSM, which waits on done.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 47 ++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the registered ALU and the control FSM decoder.
package alu_seq_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_PASS = 4'd0,
    OP_XOR  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADD  = 4'd4,
    OP_ADC  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SBC  = 4'd7,
    OP_RLC  = 4'd8,
    OP_RRC  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: one multiplier bit per step, product ready on the last step.
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_next,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     partial;

  // Upper half accumulates the multiplicand when the current multiplier bit is set,
  // then the whole product shifts right so the next multiplier bit lands in bit 0.
  always_comb begin
    partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    prod_next = {partial, prod[WIDTH-1:1]};
    last      = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (step) begin
      prod <= prod_next;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; define ALU_SEQ_MUL_EN to add the iterative
// unsigned multiply on opcode 10 (otherwise opcode 10 passes B through in one cycle).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       I,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] S_hi,
  output logic             Cout,
  output logic             Z,
  output logic             V
);

  localparam int MSB = WIDTH - 1;

  alu_op_e          op;
  logic             accept;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sc_s;
  logic             sc_cout;
  logic             sc_v;
  logic             upd;
  logic [WIDTH-1:0] nxt_s;
  logic [WIDTH-1:0] nxt_hi;
  logic             nxt_cout;
  logic             nxt_v;

  assign op     = alu_op_e'(I);
  assign accept = start && !busy;

  // Single-cycle results straight from the live inputs; they are registered at the accepting edge.
  always_comb begin
    wide    = '0;
    sc_s    = B;
    sc_cout = 1'b0;
    sc_v    = 1'b0;
    case (op)
      OP_XOR: sc_s = A ^ B;
      OP_AND: sc_s = A & B;
      OP_OR:  sc_s = A | B;
      OP_ADD, OP_ADC: begin
        wide    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin && (op == OP_ADC)};
        sc_s    = wide[WIDTH-1:0];
        sc_cout = wide[WIDTH];
        sc_v    = (A[MSB] == B[MSB]) && (wide[MSB] != A[MSB]);
      end
      OP_SUB, OP_SBC: begin
        wide    = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin && (op == OP_SBC)};
        sc_s    = wide[WIDTH-1:0];
        sc_cout = wide[WIDTH];
        sc_v    = (A[MSB] != B[MSB]) && (wide[MSB] != A[MSB]);
      end
      OP_RLC: begin
        sc_s    = {A[WIDTH-2:0], Cin};
        sc_cout = A[MSB];
      end
      OP_RRC: begin
        sc_s    = {Cin, A[WIDTH-1:1]};
        sc_cout = A[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  state_e             state;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  assign busy     = (state == MUL);
  assign mul_load = accept && (op == OP_MUL);
  assign mul_step = (state == MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (mul_load),
    .step      (mul_step),
    .a         (A),
    .b         (B),
    .prod_next (mul_prod),
    .last      (mul_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (mul_load) begin
      state <= MUL;
    end else if (mul_step && mul_last) begin
      state <= IDLE;
    end
  end

  // The multiply completes on its last step; otherwise an accepted non-MUL op completes at once.
  always_comb begin
    upd      = accept && (op != OP_MUL);
    nxt_s    = sc_s;
    nxt_hi   = '0;
    nxt_cout = sc_cout;
    nxt_v    = sc_v;
    if (mul_step && mul_last) begin
      upd      = 1'b1;
      nxt_s    = mul_prod[WIDTH-1:0];
      nxt_hi   = mul_prod[2*WIDTH-1:WIDTH];
      nxt_cout = |mul_prod[2*WIDTH-1:WIDTH];
      nxt_v    = 1'b0;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    upd      = accept;
    nxt_s    = sc_s;
    nxt_hi   = '0;
    nxt_cout = sc_cout;
    nxt_v    = sc_v;
  end
`endif

  // Result registers hold until the next completion; done pulses for each completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
      S    <= '0;
      S_hi <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b1;
    end else begin
      done <= upd;
      if (upd) begin
        S    <= nxt_s;
        S_hi <= nxt_hi;
        Cout <= nxt_cout;
        V    <= nxt_v;
        Z    <= (nxt_s == '0) && (nxt_hi == '0);
      end
    end
  end

endmodule
